// File: rtl/robot_pkg.sv
// Shared widths, timing constants, state encoding and request arbitration
// for the robot mission controller.
package robot_pkg;

    localparam int BUDGET_W      = 9;
    localparam int TRASH_W       = 8;
    localparam int REMOVE_CYCLES = 3;
    localparam int STUCK_TURNS   = 4;
    localparam int STREAK_W      = $clog2(STUCK_TURNS + 1);
    localparam int TIMER_W       = $clog2(REMOVE_CYCLES + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_REMOVE = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_STUCK  = 3'd4;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_REMOVE,
        GRANT_FRONT,
        GRANT_TURN
    } grant_e;

    // Fixed priority: removal first, then forward motion, then turning.
    function automatic grant_e arbitrate(input logic remove_req,
                                         input logic front_req,
                                         input logic turn_req);
        if (remove_req) return GRANT_REMOVE;
        if (front_req)  return GRANT_FRONT;
        if (turn_req)   return GRANT_TURN;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/removal_timer.sv
// Counts the cycles of one atomic trash removal; busy for the whole removal,
// last_o marks its final cycle.
module removal_timer
    import robot_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic start_i,
    output logic busy_o,
    output logic last_o
);

    localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(REMOVE_CYCLES);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i)                cnt_d = '0;
        else if (start_i)           cnt_d = TIMER_W'(1);
        else if (cnt_q == LAST_CNT) cnt_d = '0;
        else if (cnt_q != '0)       cnt_d = cnt_q + TIMER_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);
    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/robot_mission_ctrl.sv
// Mission sequencer for a trash-collecting robot: arbitrates navigation-core
// requests into registered actuator pulses under a move budget.
module robot_mission_ctrl
    import robot_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BUDGET_W-1:0] max_moves,
    input  logic                front_req,
    input  logic                turn_req,
    input  logic                remove_req,
    output logic                front,
    output logic                turn,
    output logic                remove,
    output logic                core_enable,
    output logic                busy,
    output logic                done,
    output logic                stuck,
    output logic [BUDGET_W-1:0] move_count,
    output logic [TRASH_W-1:0]  trash_count
);

    logic [2:0]          state_q, state_d;
    logic [BUDGET_W-1:0] budget_q, budget_d;
    logic [BUDGET_W-1:0] move_count_q, move_count_d;
    logic [TRASH_W-1:0]  trash_count_q, trash_count_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                front_q, front_d;
    logic                turn_q, turn_d;
    logic                remove_q, remove_d;
    logic                core_enable_q, busy_q, done_q, stuck_q;

    logic                timer_start, timer_clear, timer_busy, timer_last;
    grant_e              grant;
    logic [BUDGET_W-1:0] remaining, moves_next;
    logic [STREAK_W-1:0] turns_next;

    removal_timer u_removal_timer (
        .clock   (clock),
        .reset   (reset),
        .clear_i (timer_clear),
        .start_i (timer_start),
        .busy_o  (timer_busy),
        .last_o  (timer_last)
    );

    assign grant      = arbitrate(remove_req, front_req, turn_req);
    assign remaining  = budget_q - move_count_q;
    assign moves_next = move_count_q + BUDGET_W'(1);
    assign turns_next = streak_q + STREAK_W'(1);

    always_comb begin
        state_d       = state_q;
        budget_d      = budget_q;
        move_count_d  = move_count_q;
        trash_count_d = trash_count_q;
        streak_d      = streak_q;
        front_d       = 1'b0;
        turn_d        = 1'b0;
        remove_d      = 1'b0;
        timer_start   = 1'b0;
        timer_clear   = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            timer_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_STUCK: begin
                    if (start) begin
                        budget_d      = max_moves;
                        move_count_d  = '0;
                        trash_count_d = '0;
                        streak_d      = '0;
                        state_d       = (max_moves == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    case (grant)
                        GRANT_REMOVE: begin
                            // A removal may only begin if it can run to completion.
                            if (remaining >= BUDGET_W'(REMOVE_CYCLES)) begin
                                remove_d    = 1'b1;
                                timer_start = 1'b1;
                                state_d     = ST_REMOVE;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        GRANT_FRONT: begin
                            front_d  = 1'b1;
                            streak_d = '0;
                            if (moves_next == budget_q) state_d = ST_DONE;
                        end
                        GRANT_TURN: begin
                            turn_d   = 1'b1;
                            streak_d = turns_next;
                            if (turns_next == STREAK_W'(STUCK_TURNS)) state_d = ST_STUCK;
                            else if (moves_next == budget_q)          state_d = ST_DONE;
                        end
                        default: ;
                    endcase
                end
                ST_REMOVE: begin
                    if (timer_last) begin
                        if (trash_count_q != '1) trash_count_d = trash_count_q + TRASH_W'(1);
                        streak_d = '0;
                        state_d  = (move_count_q == budget_q) ? ST_DONE : ST_RUN;
                    end else begin
                        remove_d = timer_busy;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Every cycle an actuator is driven is charged against the budget on the same edge.
        if (front_d || turn_d || remove_d) move_count_d = moves_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            budget_q      <= '0;
            move_count_q  <= '0;
            trash_count_q <= '0;
            streak_q      <= '0;
            front_q       <= 1'b0;
            turn_q        <= 1'b0;
            remove_q      <= 1'b0;
            core_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            stuck_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            budget_q      <= budget_d;
            move_count_q  <= move_count_d;
            trash_count_q <= trash_count_d;
            streak_q      <= streak_d;
            front_q       <= front_d;
            turn_q        <= turn_d;
            remove_q      <= remove_d;
            core_enable_q <= (state_d == ST_RUN);
            busy_q        <= (state_d == ST_RUN) || (state_d == ST_REMOVE);
            done_q        <= (state_d == ST_DONE);
            stuck_q       <= (state_d == ST_STUCK);
        end
    end

    assign front       = front_q;
    assign turn        = turn_q;
    assign remove      = remove_q;
    assign core_enable = core_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stuck       = stuck_q;
    assign move_count  = move_count_q;
    assign trash_count = trash_count_q;

endmodule

// File: tb/tb_robot_mission_ctrl.sv
// Scoreboard bench: a mission-level reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the controller.
module tb_robot_mission_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] max_moves = '0;
    logic       front_req = 1'b0;
    logic       turn_req = 1'b0;
    logic       remove_req = 1'b0;
    logic       front, turn, remove, core_enable, busy, done, stuck;
    logic [8:0] move_count;
    logic [7:0] trash_count;

    robot_mission_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .max_moves   (max_moves),
        .front_req   (front_req),
        .turn_req    (turn_req),
        .remove_req  (remove_req),
        .front       (front),
        .turn        (turn),
        .remove      (remove),
        .core_enable (core_enable),
        .busy        (busy),
        .done        (done),
        .stuck       (stuck),
        .move_count  (move_count),
        .trash_count (trash_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       front;
        logic       turn;
        logic       remove;
        logic       core_enable;
        logic       busy;
        logic       done;
        logic       stuck;
        logic [8:0] moves;
        logic [7:0] trash;
    } obs_t;

    obs_t act;
    assign act = {front, turn, remove, core_enable, busy, done, stuck, move_count, trash_count};

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Mission-level reference model.
    typedef enum {M_IDLE, M_RUN, M_REMOVE, M_DONE, M_STUCK} mode_e;
    mode_e mode;
    int    budget, used, trash, streak, remove_left;
    bit    m_front, m_turn, m_remove;

    function automatic void model_reset();
        mode = M_IDLE;
        budget = 0; used = 0; trash = 0; streak = 0; remove_left = 0;
        m_front = 0; m_turn = 0; m_remove = 0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.front       = m_front;
        o.turn        = m_turn;
        o.remove      = m_remove;
        o.core_enable = (mode == M_RUN);
        o.busy        = (mode == M_RUN) || (mode == M_REMOVE);
        o.done        = (mode == M_DONE);
        o.stuck       = (mode == M_STUCK);
        o.moves       = 9'(used);
        o.trash       = 8'(trash);
        return o;
    endfunction

    function automatic void model_step();
        m_front = 0; m_turn = 0; m_remove = 0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (abort) begin
            mode = M_IDLE;
            remove_left = 0;
            return;
        end
        case (mode)
            M_RUN: begin
                if (remove_req) begin
                    if (budget - used >= 3) begin
                        mode = M_REMOVE; remove_left = 3; m_remove = 1;
                    end else begin
                        mode = M_DONE;
                    end
                end else if (front_req) begin
                    m_front = 1; streak = 0;
                end else if (turn_req) begin
                    m_turn = 1; streak++;
                end
                if (m_front || m_turn || m_remove) used++;
                if (mode == M_RUN && streak == 4)          mode = M_STUCK;
                else if (mode == M_RUN && used == budget)  mode = M_DONE;
            end
            M_REMOVE: begin
                remove_left--;
                if (remove_left > 0) begin
                    m_remove = 1; used++;
                end else begin
                    trash  = (trash < 255) ? trash + 1 : 255;
                    streak = 0;
                    mode   = (used == budget) ? M_DONE : M_RUN;
                end
            end
            default: begin
                if (start) begin
                    budget = int'(max_moves); used = 0; trash = 0; streak = 0;
                    mode = (max_moves == 0) ? M_DONE : M_RUN;
                end
            end
        endcase
    endfunction

    // Drive one cycle of inputs, predict the outputs after the edge, queue them.
    task automatic step(input bit s, input bit a, input int mm, input bit f, input bit t, input bit r);
        start = s; abort = a; max_moves = 9'(mm);
        front_req = f; turn_req = t; remove_req = r;
        @(posedge clock);
        model_step();
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    // Called between edges: outputs must clear at once, before the next clock.
    task automatic async_reset();
        reset = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = model_obs();
        #1;
    endtask

    int cyc = 0;
    initial begin
        obs_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle %0d outputs {f,t,r,ce,b,d,s,moves,trash}", cyc), 32'(act), 32'(e));
            end
            cyc++;
        end
    end

    initial begin
        int roll;
        model_reset();

        // Reset held, then released with no start: nothing may move.
        idle(3);
        check("reset move_count", 32'(move_count), 0);
        check("reset busy", 32'(busy), 0);
        reset = 1'b1;
        repeat (2) step(0, 0, 0, 1, 1, 1);

        // Budget of 5 with front held: five front pulses then DONE.
        step(1, 0, 5, 0, 0, 0);
        repeat (7) step(0, 0, 0, 1, 0, 0);
        check("front budget move_count", 32'(move_count), 5);
        check("front budget done", 32'(done), 1);
        check("front budget front low", 32'(front), 0);

        // Remove beats front; 3-cycle removal, back in RUN.
        step(1, 0, 10, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        idle(4);
        check("removal trash_count", 32'(trash_count), 1);
        check("removal move_count", 32'(move_count), 3);
        check("removal back in run", 32'(core_enable), 1);

        // Not enough budget left for a removal: DONE without remove.
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        check("short budget done", 32'(done), 1);
        check("short budget trash", 32'(trash_count), 0);
        check("short budget moves", 32'(move_count), 2);

        // Four straight turns -> STUCK; an intervening front prevents it.
        step(1, 0, 20, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 1, 0);
        check("turn streak stuck", 32'(stuck), 1);
        check("turn streak moves", 32'(move_count), 4);
        step(1, 0, 20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        idle(1);
        check("broken streak not stuck", 32'(stuck), 0);
        check("broken streak moves", 32'(move_count), 5);

        // Reset in the second removal cycle.
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        async_reset();
        check("async reset remove", 32'(remove), 0);
        check("async reset moves", 32'(move_count), 0);
        check("async reset busy", 32'(busy), 0);
        idle(2);
        reset = 1'b1;
        repeat (4) step(0, 0, 0, 1, 1, 1);
        check("post reset silent", 32'({front, turn, remove}), 0);

        // Zero budget, then simultaneous start and abort from DONE.
        step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 1, 1);
        check("zero budget done", 32'(done), 1);
        check("zero budget moves", 32'(move_count), 0);
        step(1, 1, 5, 0, 0, 0);
        check("abort wins done", 32'(done), 0);
        check("abort wins busy", 32'(busy), 0);

        // Randomized missions.
        for (int m = 0; m < 40; m++) begin
            step(1, 0, int'($urandom_range(0, 30)), 0, 0, 0);
            for (int c = 0; c < 40; c++) begin
                roll = int'($urandom_range(0, 99));
                if (roll == 0) begin
                    async_reset();
                    idle(1);
                    reset = 1'b1;
                end else begin
                    step($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                         int'($urandom_range(0, 30)), $urandom_range(0, 2) == 0,
                         $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0);
                end
            end
        end

        idle(2);
        @(negedge clock);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/robot_mission_ctrl.md
ROBOT_MISSION_CTRL -- requirements
Module: robot_mission_ctrl

Interface
REQ-001 SHALL have port clock  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse; begins mission, latches max_moves.
REQ-004 SHALL have port abort  input  1  forces return to IDLE.
REQ-005 SHALL have port max_moves  input  9  action budget, unsigned, sampled only on accepted start.
REQ-006 SHALL have ports front_req, turn_req, remove_req  input  1 each  action requests from robot navigation core.
REQ-007 SHALL have ports front, turn, remove  output  1 each  registered actuator commands.
REQ-008 SHALL have port core_enable  output  1  high only in RUN; navigation core advances only when high.
REQ-009 SHALL have ports busy, done, stuck  output  1 each  status flags.
REQ-010 SHALL have port move_count  output  9  actuator-active cycles consumed this mission.
REQ-011 SHALL have port trash_count  output  8  completed removals, saturating at 255.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, REMOVE, DONE, STUCK.
REQ-013 SHALL leave IDLE only on start: max_moves==0 -> DONE, else -> RUN; counters cleared on same edge.
REQ-014 SHALL, in RUN, grant at most one request per cycle, priority remove_req > front_req > turn_req; lower requests ignored that cycle.
REQ-015 SHALL drive the granted actuator output high on the edge after the request is sampled (1-cycle latency), for one cycle for front/turn.
REQ-016 SHALL increment move_count by 1 for every cycle in which front, turn or remove is high.
REQ-017 SHALL, on granted remove_req with remaining budget (max_moves - move_count) >= 3, enter REMOVE; with remaining < 3, enter DONE and not assert remove.
REQ-018 SHALL hold remove high for exactly 3 consecutive cycles in REMOVE, with front, turn, core_enable low; removal is atomic and not interrupted by budget.
REQ-019 SHALL, on the third REMOVE cycle, increment trash_count (saturating) and return to RUN, or to DONE if move_count reaches max_moves.
REQ-020 SHALL enter DONE from RUN on the edge where move_count becomes equal to max_moves.
REQ-021 SHALL count consecutive granted turns with no intervening front; reaching 4 -> STUCK on that edge (a front grant or remove completion clears the count).
REQ-022 SHALL hold DONE/STUCK with all actuator outputs low until start (restart, re-latch) or abort (IDLE).
REQ-023 SHALL, on abort in any state, go to IDLE next edge with actuator outputs low; abort wins over start when simultaneous.
REQ-024 SHALL ignore start while in RUN or REMOVE.
REQ-025 SHALL drive busy = RUN or REMOVE, done = DONE, stuck = STUCK, all from registered state.

Reset
REQ-026 SHALL on reset low immediately force state IDLE, front/turn/remove/core_enable/busy/done/stuck = 0, move_count = 0, trash_count = 0, turn streak = 0, latched budget = 0.
REQ-027 SHALL, on reset asserted mid-REMOVE, drop remove asynchronously without incrementing trash_count.
REQ-028 SHALL require a start pulse after reset release before any actuator output is asserted.

Structure
REQ-029 SHALL take state encoding, REMOVE_CYCLES=3, STUCK_TURNS=4, budget width 9 and trash width 8 from shared package robot_pkg.
REQ-030 SHALL place the 3-cycle removal timer in one sub-module removal_timer (start, busy, last-cycle pulse).
REQ-031 SHALL keep all outputs registered; no combinational path from *_req to actuator outputs.

Verification
REQ-032 SHALL verify: start, max_moves=5, front_req held high -> front high 5 cycles starting 1 cycle later, move_count=5, done=1, front=0 afterwards.
REQ-033 SHALL verify: max_moves=10, remove_req and front_req both high in one cycle -> remove high exactly 3 cycles, no front, trash_count=1, move_count=3, back in RUN.
REQ-034 SHALL verify: max_moves=4, 2 fronts then remove_req -> no remove, state DONE, trash_count=0, move_count=2.
REQ-035 SHALL verify: turn_req only, max_moves=20 -> 4 turns then stuck=1, move_count=4; turn,front,turn,turn,turn -> no stuck.
REQ-036 SHALL verify: reset low during second REMOVE cycle -> remove=0 immediately, all counters 0, IDLE; no output until next start.
REQ-037 SHALL verify: start and abort in same cycle from DONE -> IDLE; start with max_moves=0 -> DONE with zero actuator activity.
